kan_tda_job_scheduler: RTL
==========================

# kan_tda_job_scheduler

Job scheduler for the KAN/TDA accelerator. It accepts a stream of tagged jobs, each bound for either the KAN core pool or the TDA engine pool. Each job is dispatched to a free unit of the requested type by per-pool round-robin, and the block tracks per-unit busy state and ID. Unit completions are collected into an ordered completion stream. Dispatch is gated by an enable and by a thermal throttle with hysteresis. The block sits between the host control path and the `kan_tda_asic_core` compute pools, and is the source of each unit's start strobe.

## Interface
- `NUM_KAN_CORES`, 4: KAN units in the pool.
- `NUM_TDA_ENGINES`, 2: TDA units in the pool.
- `ID_WIDTH`, 4: job tag width.
- `CFIFO_DEPTH`, 8: completion FIFO entries. Must be ≥ `NUM_KAN_CORES + NUM_TDA_ENGINES`; power of two.
- `THERM_HI`, 8'hC0: throttle-on threshold.
- `THERM_LO`, 8'hA0: throttle-off threshold.

Ports (name, direction, width, meaning). One clock; reset is synchronous and active-high.
- `sys_clk`  in  1  clock; all logic on rising edge.
- `por_rst`  in  1  synchronous, active-high reset.
- `enable`  in  1  0 blocks new dispatch; in-flight jobs still complete.
- `req_valid`  in  1  job offered.
- `req_ready`  out  1  job accepted when high together with `req_valid`.
- `req_type`  in  1  0 = KAN, 1 = TDA.
- `req_id`  in  `ID_WIDTH`  job tag.
- `kan_start`  out  `NUM_KAN_CORES`  one-hot, single-cycle start pulse.
- `tda_start`  out  `NUM_TDA_ENGINES`  one-hot, single-cycle start pulse.
- `start_id`  out  `ID_WIDTH`  tag of the job being started; valid only while a start bit is high.
- `kan_done`  in  `NUM_KAN_CORES`  per-unit single-cycle completion pulses.
- `tda_done`  in  `NUM_TDA_ENGINES`  per-unit single-cycle completion pulses.
- `thermal_status`  in  8  die temperature code.
- `cmp_valid`  out  1  completion FIFO head valid.
- `cmp_ready`  in  1  consumer pop.
- `cmp_type`  out  1  type of the head entry.
- `cmp_id`  out  `ID_WIDTH`  tag of the head entry.
- `kan_busy`  out  `NUM_KAN_CORES`  per-unit busy flags.
- `tda_busy`  out  `NUM_TDA_ENGINES`  per-unit busy flags.
- `throttled`  out  1  thermal throttle active.
- `idle`  out  1  no busy unit and completion FIFO empty.
- `err_spurious`  out  1  sticky; set by a done pulse on a non-busy unit.

## Operation
- **Free unit:** a unit is free when its busy bit is 0.
- **req_ready (combinational):**
  - `enable` is high, and
  - `throttled` is low, and
  - the pool selected by `req_type` has at least one free unit, and
  - `fifo_count + total_busy < CFIFO_DEPTH`. This is the credit rule; it guarantees the FIFO never overflows.
- **Grant selection:** round-robin within the selected pool. The search starts at last-granted index + 1 and wraps. After reset the pointer is set so that the first grant goes to unit 0. Only the accepted pool's pointer advances.
- **Handshake (`req_valid & req_ready`):**
  - The chosen unit's busy bit sets.
  - The unit's stored ID latches `req_id`.
  - The unit's start bit pulses and `start_id = req_id`.
  - At most one dispatch per cycle.
- **Done pulse on a busy unit:**
  - The busy bit clears.
  - `{type, stored_id}` is pushed to the FIFO.
  - Several dones in the same cycle are all pushed that cycle, in order KAN 0..N-1 then TDA 0..M-1.
- **Done pulse on a non-busy unit:** ignored (no push, no state change) and `err_spurious` sets. It stays set until reset.
- **FIFO:**
  - `cmp_valid` is high while the FIFO is non-empty; `cmp_type`/`cmp_id` show the head.
  - Pop on `cmp_valid & cmp_ready`.
  - Push and pop in the same cycle are both honoured.
  - `cmp_type`/`cmp_id` hold their value while `cmp_ready` is low.
- **Throttle (registered):**
  - Sets when `thermal_status > THERM_HI`.
  - Clears when `thermal_status < THERM_LO`.
  - Holds its value in between.
  - In-flight jobs and the completion path are unaffected.
- **Reset:**
  - All busy bits, stored IDs, pointers, FIFO pointers/count, `throttled` and `err_spurious` clear.
  - Output reset values: all start bits 0, `cmp_valid` 0, `req_ready` follows its definition, `idle` 1.
  - A reset mid-job abandons the job. A later done from that unit is flagged as spurious.

## Timing
- **Accept → start:** handshake in cycle N → start pulse and busy bit high in cycle N+1, for exactly one cycle.
- **Done → completion:** done in cycle M → busy bit low in cycle M+1. `cmp_valid` goes high in M+1 if the FIFO was empty (1-cycle latency).
- **Unit reuse:** the freed unit is grantable from cycle M+1. A done and a request arriving for the same unit in the same cycle do not grant that unit that cycle.
- **Throttle latency:** a `thermal_status` change → `throttled` updates at the next edge → `req_ready` is affected in that same following cycle.
- **enable:** acts combinationally on `req_ready`.
- **idle:** registered-equivalent. It is high in the cycle after the last busy bit clears and the FIFO is empty.

## Test plan
- **Round-robin and handshake.** Reset; 5 KAN requests back-to-back with IDs 1..5 → `kan_start` = 0001, 0010, 0100, 1000 in consecutive cycles. The 5th request stalls (`req_ready` = 0) until a done arrives; a `kan_done` = 0010 frees unit 1, and ID 5 then starts on unit 1.
- **Simultaneous completions.** Dispatch KAN IDs 1, 2 and TDA ID 3; pulse `kan_done` = 0011 and `tda_done` = 01 in one cycle with `cmp_ready` = 0 → FIFO holds (0,1), (0,2), (1,3) in that order; `idle` = 0.
- **Credit rule.** With `CFIFO_DEPTH` = 8: fill 6 completions with `cmp_ready` = 0, then dispatch 2 more → `req_ready` = 0 even though units are free. After 1 pop → `req_ready` = 1.
- **Throttle hysteresis.** Drive `thermal_status` = 0xC1 → `throttled` = 1 next cycle and `req_ready` = 0. Drive 0xB0 → still throttled. Drive 0x9F → `throttled` = 0 and dispatch resumes. In-flight done completions still appear on `cmp_*` throughout.
- **Spurious done.** `tda_done` = 10 with no TDA unit busy → `err_spurious` = 1, no FIFO push. `err_spurious` stays 1 until `por_rst`.
- **Reset mid-operation.** Assert `por_rst` with 3 units busy and 2 FIFO entries → next cycle all busy bits 0, `cmp_valid` = 0, `idle` = 1. A subsequent done from a formerly busy unit sets `err_spurious`.

Source files
------------

// File: rtl/kan_tda_job_scheduler_if.sv
// Job request, unit start/done, thermal and completion-stream signals of the KAN/TDA job scheduler.
// The scheduler uses the slave modport; the host and compute pools drive the master side.
interface kan_tda_job_scheduler_if #(
    parameter int NUM_KAN_CORES   = 4,
    parameter int NUM_TDA_ENGINES = 2,
    parameter int ID_WIDTH        = 4
);
    // Job intake handshake: a job is taken on a cycle where req_valid and req_ready are
    // both high; req_type/req_id must be stable while req_valid waits for req_ready.
    // Completion stream: an entry is popped on a cycle where cmp_valid and cmp_ready are both high.
    logic                       enable;
    logic                       req_valid;
    logic                       req_ready;
    logic                       req_type;
    logic [ID_WIDTH-1:0]        req_id;
    logic [NUM_KAN_CORES-1:0]   kan_start;
    logic [NUM_TDA_ENGINES-1:0] tda_start;
    logic [ID_WIDTH-1:0]        start_id;
    logic [NUM_KAN_CORES-1:0]   kan_done;
    logic [NUM_TDA_ENGINES-1:0] tda_done;
    logic [7:0]                 thermal_status;
    logic                       cmp_valid;
    logic                       cmp_ready;
    logic                       cmp_type;
    logic [ID_WIDTH-1:0]        cmp_id;
    logic [NUM_KAN_CORES-1:0]   kan_busy;
    logic [NUM_TDA_ENGINES-1:0] tda_busy;
    logic                       throttled;
    logic                       idle;
    logic                       err_spurious;

    modport slave (
        input  enable, req_valid, req_type, req_id, kan_done, tda_done, thermal_status, cmp_ready,
        output req_ready, kan_start, tda_start, start_id, cmp_valid, cmp_type, cmp_id,
               kan_busy, tda_busy, throttled, idle, err_spurious
    );

    modport master (
        output enable, req_valid, req_type, req_id, kan_done, tda_done, thermal_status, cmp_ready,
        input  req_ready, kan_start, tda_start, start_id, cmp_valid, cmp_type, cmp_id,
               kan_busy, tda_busy, throttled, idle, err_spurious
    );
endinterface

// File: rtl/kan_tda_job_scheduler.sv
// Dispatches tagged jobs to KAN/TDA units by per-pool round-robin, tracks unit busy/ID state,
// and collects unit completions into an ordered completion FIFO under a thermal throttle.
module kan_tda_job_scheduler #(
    parameter int         NUM_KAN_CORES   = 4,
    parameter int         NUM_TDA_ENGINES = 2,
    parameter int         ID_WIDTH        = 4,
    parameter int         CFIFO_DEPTH     = 8,
    parameter logic [7:0] THERM_HI        = 8'hC0,
    parameter logic [7:0] THERM_LO        = 8'hA0
) (
    input logic                    sys_clk,
    input logic                    por_rst,
    kan_tda_job_scheduler_if.slave io
);
    localparam int NK = NUM_KAN_CORES;
    localparam int NT = NUM_TDA_ENGINES;
    localparam int NU = NK + NT;
    localparam int PW = $clog2(CFIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int KW = (NK > 1) ? $clog2(NK) : 1;
    localparam int TW = (NT > 1) ? $clog2(NT) : 1;

    logic [NK-1:0]       r_kan_busy;
    logic [NT-1:0]       r_tda_busy;
    logic [NK-1:0]       r_kan_start;
    logic [NT-1:0]       r_tda_start;
    logic [ID_WIDTH-1:0] r_kan_id [NK];
    logic [ID_WIDTH-1:0] r_tda_id [NT];
    logic [ID_WIDTH-1:0] r_start_id;
    logic [KW-1:0]       r_kan_last;
    logic [TW-1:0]       r_tda_last;
    logic [ID_WIDTH:0]   r_fifo [CFIFO_DEPTH];
    logic [PW-1:0]       r_wr_ptr;
    logic [PW-1:0]       r_rd_ptr;
    logic [CW-1:0]       r_count;
    logic                r_throttled;
    logic                r_err_spurious;

    logic [NU-1:0]       w_done_all;
    logic [NU-1:0]       w_busy_all;
    logic [ID_WIDTH:0]   w_entry [NU];
    logic [CW-1:0]       w_slot [NU];
    logic [CW-1:0]       w_npush;
    logic [CW-1:0]       w_total_busy;
    logic                w_credit_ok;
    logic                w_kan_found;
    logic                w_tda_found;
    logic [KW-1:0]       w_kan_idx;
    logic [TW-1:0]       w_tda_idx;
    logic [KW-1:0]       w_kan_sel;
    logic [TW-1:0]       w_tda_sel;
    logic                w_req_ready;
    logic                w_accept;
    logic                w_pop;

    // Units are flattened KAN 0..NK-1 then TDA 0..NT-1, which is also the FIFO push order.
    always_comb begin
        w_done_all   = {io.tda_done, io.kan_done};
        w_busy_all   = {r_tda_busy, r_kan_busy};
        w_npush      = '0;
        w_total_busy = '0;
        for (int k = 0; k < NK; k++) w_entry[k] = {1'b0, r_kan_id[k]};
        for (int t = 0; t < NT; t++) w_entry[NK+t] = {1'b1, r_tda_id[t]};
        for (int u = 0; u < NU; u++) begin
            w_slot[u] = w_npush;
            if (w_done_all[u] && w_busy_all[u]) w_npush = w_npush + CW'(1);
            if (w_busy_all[u]) w_total_busy = w_total_busy + CW'(1);
        end
        // Every busy unit holds a reserved FIFO slot, so simultaneous completions always fit.
        w_credit_ok = ({1'b0, r_count} + {1'b0, w_total_busy}) < (CW+1)'(CFIFO_DEPTH);
    end

    always_comb begin
        w_kan_found = 1'b0;
        w_kan_sel   = r_kan_last;
        w_kan_idx   = '0;
        for (int off = 1; off <= NK; off++) begin
            w_kan_idx = KW'((int'(r_kan_last) + off) % NK);
            if (!w_kan_found && !r_kan_busy[w_kan_idx]) begin
                w_kan_found = 1'b1;
                w_kan_sel   = w_kan_idx;
            end
        end
        w_tda_found = 1'b0;
        w_tda_sel   = r_tda_last;
        w_tda_idx   = '0;
        for (int off = 1; off <= NT; off++) begin
            w_tda_idx = TW'((int'(r_tda_last) + off) % NT);
            if (!w_tda_found && !r_tda_busy[w_tda_idx]) begin
                w_tda_found = 1'b1;
                w_tda_sel   = w_tda_idx;
            end
        end
    end

    assign w_req_ready = io.enable && !r_throttled && w_credit_ok &&
                         (io.req_type ? w_tda_found : w_kan_found);
    assign w_accept    = io.req_valid && w_req_ready;
    assign w_pop       = (r_count != '0) && io.cmp_ready;

    always_ff @(posedge sys_clk) begin
        if (por_rst) begin
            r_kan_busy     <= '0;
            r_tda_busy     <= '0;
            r_kan_start    <= '0;
            r_tda_start    <= '0;
            r_start_id     <= '0;
            for (int k = 0; k < NK; k++) r_kan_id[k] <= '0;
            for (int t = 0; t < NT; t++) r_tda_id[t] <= '0;
            r_kan_last     <= KW'(NK - 1);
            r_tda_last     <= TW'(NT - 1);
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_throttled    <= 1'b0;
            r_err_spurious <= 1'b0;
        end else begin
            r_kan_start <= '0;
            r_tda_start <= '0;
            for (int k = 0; k < NK; k++)
                if (io.kan_done[k] && r_kan_busy[k]) r_kan_busy[k] <= 1'b0;
            for (int t = 0; t < NT; t++)
                if (io.tda_done[t] && r_tda_busy[t]) r_tda_busy[t] <= 1'b0;
            // The granted unit was free this cycle, so it cannot also be clearing on a done.
            if (w_accept) begin
                r_start_id <= io.req_id;
                if (io.req_type) begin
                    r_tda_busy[w_tda_sel]  <= 1'b1;
                    r_tda_id[w_tda_sel]    <= io.req_id;
                    r_tda_start[w_tda_sel] <= 1'b1;
                    r_tda_last             <= w_tda_sel;
                end else begin
                    r_kan_busy[w_kan_sel]  <= 1'b1;
                    r_kan_id[w_kan_sel]    <= io.req_id;
                    r_kan_start[w_kan_sel] <= 1'b1;
                    r_kan_last             <= w_kan_sel;
                end
            end
            for (int u = 0; u < NU; u++)
                if (w_done_all[u] && w_busy_all[u])
                    r_fifo[r_wr_ptr + PW'(w_slot[u])] <= w_entry[u];
            r_wr_ptr <= r_wr_ptr + PW'(w_npush);
            if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
            r_count <= r_count + w_npush - CW'(w_pop);
            if (io.thermal_status > THERM_HI)      r_throttled <= 1'b1;
            else if (io.thermal_status < THERM_LO) r_throttled <= 1'b0;
            if (|(w_done_all & ~w_busy_all)) r_err_spurious <= 1'b1;
        end
    end

    assign io.req_ready    = w_req_ready;
    assign io.kan_start    = r_kan_start;
    assign io.tda_start    = r_tda_start;
    assign io.start_id     = r_start_id;
    assign io.cmp_valid    = (r_count != '0);
    assign io.cmp_type     = r_fifo[r_rd_ptr][ID_WIDTH];
    assign io.cmp_id       = r_fifo[r_rd_ptr][ID_WIDTH-1:0];
    assign io.kan_busy     = r_kan_busy;
    assign io.tda_busy     = r_tda_busy;
    assign io.throttled    = r_throttled;
    assign io.idle         = (r_kan_busy == '0) && (r_tda_busy == '0) && (r_count == '0);
    assign io.err_spurious = r_err_spurious;
endmodule
